// File: rtl/data_sram_if.sv
// LSU <-> data SRAM request/response bundle.
// The master is the LSU and the slave is the memory responder.
interface data_sram_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [3:0]  data_ram_sel;
  logic        data_unsigned;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] data_sram_rdata;
  logic [31:0] load_data;

  modport master (
    output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
           data_ram_sel, data_unsigned,
    input  req_ready, resp_valid, data_sram_rdata, load_data
  );

  modport slave (
    input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
           data_ram_sel, data_unsigned,
    output req_ready, resp_valid, data_sram_rdata, load_data
  );
endinterface

// File: rtl/data_sram_resp.sv
// Data-SRAM responder: byte-masked stores, lane-extracted loads, and
// WAIT_CYCLES extra access cycles so core stall paths can be exercised.
//
// state  | meaning
// IDLE   | ready for a request, req_ready=1
// ACCESS | wait-state countdown, array access on the cycle cnt==0
// RESP   | one-cycle resp_valid pulse, then back to IDLE
module data_sram_resp #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  data_sram_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                  state, state_nx;
  logic [3:0]              cnt;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [3:0]              we_q;
  logic [31:0]             wdata_q;
  logic [3:0]              sel_q;
  logic                    uns_q;
  logic [31:0]             mem [2**DEPTH_LOG2];
  logic                    commit;
  logic                    unused_addr;

  // Upper address bits alias onto the array; low two select a lane only.
  assign unused_addr = ^{bus.data_sram_addr[31:DEPTH_LOG2+2], bus.data_sram_addr[1:0]};

  function automatic logic [31:0] extract(input logic [31:0] w,
                                          input logic [3:0]  sel,
                                          input logic        uns);
    logic [31:0] r;
    r = '0;
    case (sel)
      4'b0001: r = {{24{~uns & w[7]}},  w[7:0]};
      4'b0010: r = {{24{~uns & w[15]}}, w[15:8]};
      4'b0100: r = {{24{~uns & w[23]}}, w[23:16]};
      4'b1000: r = {{24{~uns & w[31]}}, w[31:24]};
      4'b0011: r = {{16{~uns & w[15]}}, w[15:0]};
      4'b1100: r = {{16{~uns & w[31]}}, w[31:16]};
      4'b1111: r = w;
      default: r = '0;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.data_sram_en) state_nx = ACCESS;
      end
      ACCESS: if (cnt == 4'd0) state_nx = RESP;
      RESP: begin
        bus.resp_valid = 1'b1;
        state_nx       = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign commit = !rst && (state == ACCESS) && (cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt                 <= '0;
      idx_q               <= '0;
      we_q                <= '0;
      wdata_q             <= '0;
      sel_q               <= '0;
      uns_q               <= 1'b0;
      bus.data_sram_rdata <= '0;
      bus.load_data       <= '0;
    end else begin
      if (state == IDLE && bus.data_sram_en) begin
        idx_q   <= bus.data_sram_addr[DEPTH_LOG2+1:2];
        we_q    <= bus.data_sram_we;
        wdata_q <= bus.data_sram_wdata;
        sel_q   <= bus.data_ram_sel;
        uns_q   <= bus.data_unsigned;
        cnt     <= 4'(WAIT_CYCLES);
      end else if (state == ACCESS) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else if (we_q == 4'b0000) begin
          bus.data_sram_rdata <= mem[idx_q];
          bus.load_data       <= extract(mem[idx_q], sel_q, uns_q);
        end
      end
    end
  end

  // Array has no reset; a commit coinciding with rst is dropped.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (we_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp: three instances with WAIT_CYCLES 0, 3
// and 2 covering loads/stores, wait states, aliasing and mid-store reset.
module tb_data_sram_resp;

  localparam int W0 = 0;
  localparam int W1 = 3;
  localparam int W2 = 2;

  logic        clk;
  logic [2:0]  rst;
  logic [2:0]  en;
  logic [3:0]  r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_sel;
  logic        r_uns;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] exp_rd [3];
  logic [31:0] exp_ld [3];

  data_sram_if bus0 ();
  data_sram_if bus1 ();
  data_sram_if bus2 ();

  assign bus0.data_sram_en = en[0];
  assign bus1.data_sram_en = en[1];
  assign bus2.data_sram_en = en[2];
  assign bus0.data_sram_we = r_we;    assign bus1.data_sram_we = r_we;    assign bus2.data_sram_we = r_we;
  assign bus0.data_sram_addr = r_addr; assign bus1.data_sram_addr = r_addr; assign bus2.data_sram_addr = r_addr;
  assign bus0.data_sram_wdata = r_wdata; assign bus1.data_sram_wdata = r_wdata; assign bus2.data_sram_wdata = r_wdata;
  assign bus0.data_ram_sel = r_sel;   assign bus1.data_ram_sel = r_sel;   assign bus2.data_ram_sel = r_sel;
  assign bus0.data_unsigned = r_uns;  assign bus1.data_unsigned = r_uns;  assign bus2.data_unsigned = r_uns;

  data_sram_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(W0)) dut0 (.clk(clk), .rst(rst[0]), .bus(bus0));
  data_sram_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(W1)) dut1 (.clk(clk), .rst(rst[1]), .bus(bus1));
  data_sram_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(W2)) dut2 (.clk(clk), .rst(rst[2]), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wait_of(input int k);
    return (k == 0) ? W0 : (k == 1) ? W1 : W2;
  endfunction

  function automatic logic get_ready(input int k);
    return (k == 0) ? bus0.req_ready : (k == 1) ? bus1.req_ready : bus2.req_ready;
  endfunction

  function automatic logic get_valid(input int k);
    return (k == 0) ? bus0.resp_valid : (k == 1) ? bus1.resp_valid : bus2.resp_valid;
  endfunction

  function automatic logic [31:0] get_rdata(input int k);
    return (k == 0) ? bus0.data_sram_rdata : (k == 1) ? bus1.data_sram_rdata : bus2.data_sram_rdata;
  endfunction

  function automatic logic [31:0] get_load(input int k);
    return (k == 0) ? bus0.load_data : (k == 1) ? bus1.load_data : bus2.load_data;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One full transaction on instance k. For stores exp_* are ignored and the
  // previously loaded outputs must be held. hold keeps a junk store request
  // asserted while busy; it must not be accepted.
  task automatic xact(input int k, input logic [3:0] we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] sel, input logic uns,
                      input logic [31:0] e_rd, input logic [31:0] e_ld, input bit hold);
    int n;
    int lows;
    chk("ready_idle", 32'(get_ready(k)), 32'd1);
    en[k] = 1'b1; r_we = we; r_addr = addr; r_wdata = wdata; r_sel = sel; r_uns = uns;
    @(posedge clk); #1;
    if (hold) begin
      r_we = 4'hF; r_wdata = 32'hBADBADBA; r_sel = 4'hF;
    end else begin
      en[k] = 1'b0;
    end
    lows = 0;
    for (n = 0; n < 40; n++) begin
      if (!get_ready(k)) lows++;
      if (get_valid(k)) break;
      @(posedge clk); #1;
    end
    en[k] = 1'b0;
    chk("resp_latency", 32'(n), 32'(wait_of(k) + 1));
    chk("busy_cycles", 32'(lows), 32'(wait_of(k) + 2));
    if (we == 4'b0000) begin
      exp_rd[k] = e_rd;
      exp_ld[k] = e_ld;
    end
    chk("rdata", get_rdata(k), exp_rd[k]);
    chk("load_data", get_load(k), exp_ld[k]);
    @(posedge clk); #1;
    chk("valid_pulse_end", 32'(get_valid(k)), 32'd0);
  endtask

  initial begin
    int seen;
    rst = 3'b111; en = 3'b000;
    r_we = '0; r_addr = '0; r_wdata = '0; r_sel = '0; r_uns = 1'b0;
    for (int k = 0; k < 3; k++) begin exp_rd[k] = '0; exp_ld[k] = '0; end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", 32'(get_ready(k)), 32'd1);
      chk("rst_valid", 32'(get_valid(k)), 32'd0);
      chk("rst_rdata", get_rdata(k), 32'h0);
      chk("rst_load", get_load(k), 32'h0);
    end
    rst = 3'b000;

    // Instance 0, no wait states
    xact(0, 4'hF, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 0, 0, 0);
    xact(0, 4'h0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 0);
    xact(0, 4'hF, 32'h20, 32'h0, 4'hF, 1'b0, 0, 0, 0);
    xact(0, 4'b0100, 32'h22, 32'h80808080, 4'b0100, 1'b0, 0, 0, 0);
    xact(0, 4'h0, 32'h20, 32'h0, 4'hF, 1'b0, 32'h00800000, 32'h00800000, 0);
    xact(0, 4'h0, 32'h22, 32'h0, 4'b0100, 1'b0, 32'h00800000, 32'hFFFFFF80, 0);
    xact(0, 4'h0, 32'h22, 32'h0, 4'b0100, 1'b1, 32'h00800000, 32'h00000080, 0);
    xact(0, 4'hF, 32'h30, 32'h80017FFF, 4'hF, 1'b0, 0, 0, 0);
    xact(0, 4'h0, 32'h32, 32'h0, 4'b1100, 1'b0, 32'h80017FFF, 32'hFFFF8001, 0);
    xact(0, 4'h0, 32'h30, 32'h0, 4'b0011, 1'b0, 32'h80017FFF, 32'h00007FFF, 0);
    xact(0, 4'h0, 32'h32, 32'h0, 4'b1100, 1'b1, 32'h80017FFF, 32'h00008001, 0);
    xact(0, 4'h0, 32'h33, 32'h0, 4'b1000, 1'b0, 32'h80017FFF, 32'hFFFFFF80, 0);
    xact(0, 4'h0, 32'h30, 32'h0, 4'b0001, 1'b0, 32'h80017FFF, 32'hFFFFFFFF, 0);
    xact(0, 4'h0, 32'h31, 32'h0, 4'b0010, 1'b1, 32'h80017FFF, 32'h0000007F, 0);
    xact(0, 4'h0, 32'h30, 32'h0, 4'b0101, 1'b0, 32'h80017FFF, 32'h00000000, 0);
    xact(0, 4'hF, 32'h00001000, 32'h11223344, 4'hF, 1'b0, 0, 0, 0);
    xact(0, 4'h0, 32'h00000000, 32'h0, 4'hF, 1'b0, 32'h11223344, 32'h11223344, 0);

    // Instance 1, three wait states, request held high while busy
    xact(1, 4'hF, 32'h40, 32'hCAFEF00D, 4'hF, 1'b0, 0, 0, 1);
    xact(1, 4'h0, 32'h40, 32'h0, 4'hF, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D, 0);

    // Instance 2, two wait states, reset lands on the store commit edge
    xact(2, 4'hF, 32'h8, 32'h55555555, 4'hF, 1'b0, 0, 0, 0);
    xact(2, 4'h0, 32'h8, 32'h0, 4'hF, 1'b0, 32'h55555555, 32'h55555555, 0);
    en[2] = 1'b1; r_we = 4'hF; r_addr = 32'h8; r_wdata = 32'hAAAAAAAA; r_sel = 4'hF;
    @(posedge clk); #1;
    en[2] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_busy", 32'(get_ready(2)), 32'd0);
    chk("abort_no_valid_yet", 32'(get_valid(2)), 32'd0);
    rst[2] = 1'b1;
    @(posedge clk); #1;
    rst[2] = 1'b0;
    chk("abort_ready", 32'(get_ready(2)), 32'd1);
    chk("abort_valid", 32'(get_valid(2)), 32'd0);
    chk("abort_rdata", get_rdata(2), 32'h0);
    chk("abort_load", get_load(2), 32'h0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (get_valid(2)) seen = 1;
      @(posedge clk); #1;
    end
    chk("abort_no_resp", 32'(seen), 32'd0);
    exp_rd[2] = '0; exp_ld[2] = '0;
    xact(2, 4'h0, 32'h8, 32'h0, 4'hF, 1'b0, 32'h55555555, 32'h55555555, 0);

    // Reset and request in the same cycle: reset wins
    en[2] = 1'b1; rst[2] = 1'b1; r_we = 4'hF; r_addr = 32'h8; r_wdata = 32'h12345678;
    @(posedge clk); #1;
    en[2] = 1'b0; rst[2] = 1'b0;
    chk("rst_wins_ready", 32'(get_ready(2)), 32'd1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (get_valid(2)) seen = 1;
      @(posedge clk); #1;
    end
    chk("rst_wins_no_resp", 32'(seen), 32'd0);
    exp_rd[2] = '0; exp_ld[2] = '0;
    xact(2, 4'h0, 32'h8, 32'h0, 4'hF, 1'b0, 32'h55555555, 32'h55555555, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
